// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling with a 3-sample majority vote per bit.
// Bytes are delivered through a single-entry valid/ready register; framing errors and overruns pulse for one cycle.
module uart_rx #(
   parameter int CLK_HZ     = 25_000_000,
   parameter int BAUD       = 115_200,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

   if (OVERSAMPLE != 16) begin : g_bad_oversample
      $error("uart_rx: OVERSAMPLE must be 16");
   end
   if (DIV < 2) begin : g_bad_div
      $error("uart_rx: CLK_HZ/BAUD too small, tick divider below 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t          state, state_nxt;
   logic            sync1, rx_s;
   logic [DW-1:0]   div_cnt;
   logic [3:0]      sc;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic            s7, s8;
   logic            stop_ok_q, stop_bad_q;

   logic            tick, tick9, tick15, maj;
   logic            start_det, shift_en, good_stop, bad_stop;

   assign tick   = (div_cnt == DW'(DIV - 1));
   assign tick9  = tick && (sc == 4'd9);
   assign tick15 = tick && (sc == 4'd15);
   assign maj    = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      start_det = 1'b0;
      shift_en  = 1'b0;
      good_stop = 1'b0;
      bad_stop  = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rx_s) begin
               start_det = 1'b1;
               state_nxt = S_START;
            end
         end
         S_START: begin
            if (tick9 && maj) state_nxt = S_IDLE;
            else if (tick15)  state_nxt = S_DATA;
         end
         S_DATA: begin
            shift_en = tick9;
            if (tick15 && bit_idx == 3'd7) state_nxt = S_STOP;
         end
         S_STOP: begin
            // Leave at mid-stop so a back-to-back start edge is never missed.
            if (tick9) begin
               if (maj) begin
                  good_stop = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  bad_stop  = 1'b1;
                  state_nxt = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            if (rx_s) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state is assigned with <= only, so every flop samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1      <= 1'b1;
         rx_s       <= 1'b1;
         div_cnt    <= '0;
         sc         <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         s7         <= 1'b1;
         s8         <= 1'b1;
         stop_ok_q  <= 1'b0;
         stop_bad_q <= 1'b0;
      end else begin
         sync1      <= rx;
         rx_s       <= sync1;
         stop_ok_q  <= good_stop;
         stop_bad_q <= bad_stop;

         if (start_det || tick) div_cnt <= '0;
         else                   div_cnt <= div_cnt + 1'b1;

         if (start_det) sc <= '0;
         else if (tick) sc <= sc + 4'd1;

         if (tick && sc == 4'd7) s7 <= rx_s;
         if (tick && sc == 4'd8) s8 <= rx_s;

         if (start_det)                    bit_idx <= '0;
         else if (state == S_DATA && tick15) bit_idx <= bit_idx + 3'd1;

         if (shift_en) shreg <= {maj, shreg[7:1]};
      end
   end

   // Output register: a byte finishing while the previous one is still held is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= stop_bad_q;
         overrun   <= 1'b0;
         if (stop_ok_q && (!rx_valid || rx_ready)) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else begin
            if (stop_ok_q)            overrun  <= 1'b1;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed 8N1 frames plus a randomized burst,
// checked against a byte-level model of what the line carried.
module tb_uart_rx;

   localparam int CLK_HZ   = 3_200_000;
   localparam int BAUD     = 100_000;
   localparam int BIT_CLKS = CLK_HZ / BAUD;
   localparam int DIV      = (CLK_HZ + BAUD * 8) / (BAUD * 16);
   // First pin sample of the start bit to rx_valid rise: synchronizer, frame to stop tick 9, output stage.
   localparam int LAT      = 2 + (16 * 9 + 10) * DIV + 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;

   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;

   // Monitor state (written only by the monitor process).
   logic [7:0]  got [0:255];
   int          n_got = 0, n_rise = 0, n_vcyc = 0, n_ferr = 0, n_ovr = 0;
   int unsigned rise_cyc = 0, ferr_cyc = 0, ovr_cyc = 0;
   logic        prev_valid = 1'b0;

   // Snapshots taken by the stimulus process.
   int b_got, b_rise, b_vcyc, b_ferr, b_ovr;
   int rd = 0;

   uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_valid && rx_ready && n_got < 256) begin
         got[n_got] = rx_data;
         n_got++;
      end
      if (rx_valid && !prev_valid) begin
         n_rise++;
         rise_cyc = cyc;
      end
      if (rx_valid) n_vcyc++;
      if (frame_err) begin
         n_ferr++;
         ferr_cyc = cyc;
      end
      if (overrun) begin
         n_ovr++;
         ovr_cyc = cyc;
      end
      prev_valid = rx_valid;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_level(input logic v, input int n);
      repeat (n) begin
         @(posedge clk); #1;
         rx = v;
      end
   endtask

   // Drives the first nbits of an 8N1 frame; p1 is the clock index that samples the start bit first.
   task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit glitch,
                             input int nbits, output int unsigned p1);
      logic [9:0] fb;
      fb = {stop_v, b, 1'b0};
      p1 = 0;
      for (int i = 0; i < nbits; i++) begin
         for (int k = 0; k < BIT_CLKS; k++) begin
            @(posedge clk); #1;
            if (i == 0 && k == 0) p1 = cyc + 1;
            rx = (glitch && i >= 1 && i <= 8 && k == 18) ? ~fb[i] : fb[i];
         end
      end
   endtask

   task automatic snap();
      b_got  = n_got;
      b_rise = n_rise;
      b_vcyc = n_vcyc;
      b_ferr = n_ferr;
      b_ovr  = n_ovr;
   endtask

   initial begin
      logic [7:0]  exp_q[$];
      logic [7:0]  rb;
      bit          bad;
      int          gap;
      int          n_bad;
      int unsigned p1;

      reset    = 1'b1;
      rx       = 1'b1;
      rx_ready = 1'b1;
      repeat (5) @(negedge clk);
      check("reset_rx_valid", 32'(rx_valid), 32'd0);
      check("reset_rx_data", 32'(rx_data), 32'h00);
      check("reset_frame_err", 32'(frame_err), 32'd0);
      check("reset_overrun", 32'(overrun), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      drive_level(1'b1, 20);

      // Single byte: data, one-cycle valid, latency, no error pulses.
      snap();
      send_frame(8'hA5, 1'b1, 1'b0, 10, p1);
      drive_level(1'b1, 20);
      check("a5_count", n_got - b_got, 1);
      check("a5_data", 32'(got[rd]), 32'hA5);
      rd = n_got;
      check("a5_valid_cycles", n_vcyc - b_vcyc, 1);
      check("a5_latency", rise_cyc - p1, LAT);
      check("a5_no_ferr", n_ferr - b_ferr, 0);
      check("a5_no_ovr", n_ovr - b_ovr, 0);

      // Back-to-back frames with no idle gap.
      snap();
      send_frame(8'h00, 1'b1, 1'b0, 10, p1);
      send_frame(8'hFF, 1'b1, 1'b0, 10, p1);
      send_frame(8'h55, 1'b1, 1'b0, 10, p1);
      drive_level(1'b1, 20);
      check("b2b_count", n_got - b_got, 3);
      check("b2b_byte0", 32'(got[rd]), 32'h00);
      check("b2b_byte1", 32'(got[rd + 1]), 32'hFF);
      check("b2b_byte2", 32'(got[rd + 2]), 32'h55);
      check("b2b_no_ovr", n_ovr - b_ovr, 0);
      rd = n_got;

      // Short low glitch in idle is a false start.
      snap();
      drive_level(1'b0, 8);
      drive_level(1'b1, 3 * BIT_CLKS);
      check("false_start_no_valid", n_rise - b_rise, 0);
      check("false_start_no_ferr", n_ferr - b_ferr, 0);

      // Stop bit low then a held-low line: one frame_err only.
      snap();
      send_frame(8'h3C, 1'b0, 1'b0, 10, p1);
      drive_level(1'b0, 200);
      check("ferr_count", n_ferr - b_ferr, 1);
      check("ferr_timing", ferr_cyc - p1, LAT);
      check("ferr_no_valid", n_rise - b_rise, 0);
      drive_level(1'b1, BIT_CLKS);
      send_frame(8'h81, 1'b1, 1'b0, 10, p1);
      drive_level(1'b1, 20);
      check("after_break_count", n_got - b_got, 1);
      check("after_break_data", 32'(got[rd]), 32'h81);
      check("after_break_ferr_total", n_ferr - b_ferr, 1);
      rd = n_got;

      // Overrun: consumer stalled while two bytes arrive.
      snap();
      @(posedge clk); #1;
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1, 1'b0, 10, p1);
      drive_level(1'b1, 10);
      send_frame(8'h22, 1'b1, 1'b0, 10, p1);
      drive_level(1'b1, 20);
      check("ovr_data_held", 32'(rx_data), 32'h11);
      check("ovr_valid_held", 32'(rx_valid), 32'd1);
      check("ovr_count", n_ovr - b_ovr, 1);
      check("ovr_timing", ovr_cyc - p1, LAT);
      check("ovr_no_ferr", n_ferr - b_ferr, 0);
      @(posedge clk); #1;
      rx_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("ovr_valid_drops", 32'(rx_valid), 32'd0);
      drive_level(1'b1, 2);
      check("ovr_transfer_count", n_got - b_got, 1);
      check("ovr_transfer_data", 32'(got[rd]), 32'h11);
      rd = n_got;

      // Single-clock inverted glitch at tick 8 of every data bit.
      snap();
      send_frame(8'hC3, 1'b1, 1'b1, 10, p1);
      drive_level(1'b1, 20);
      check("glitch_count", n_got - b_got, 1);
      check("glitch_data", 32'(got[rd]), 32'hC3);
      rd = n_got;

      // Reset in the middle of a frame, with a byte held in the output register.
      @(posedge clk); #1;
      rx_ready = 1'b0;
      send_frame(8'h5A, 1'b1, 1'b0, 10, p1);
      drive_level(1'b1, 10);
      check("pre_reset_valid", 32'(rx_valid), 32'd1);
      send_frame(8'hE7, 1'b1, 1'b0, 5, p1);
      @(posedge clk); #1;
      reset = 1'b1;
      rx    = 1'b1;
      repeat (2) @(negedge clk);
      check("midreset_rx_valid", 32'(rx_valid), 32'd0);
      check("midreset_rx_data", 32'(rx_data), 32'h00);
      check("midreset_frame_err", 32'(frame_err), 32'd0);
      check("midreset_overrun", 32'(overrun), 32'd0);
      @(posedge clk); #1;
      reset    = 1'b0;
      rx_ready = 1'b1;
      snap();
      drive_level(1'b1, 100);
      check("post_reset_quiet_valid", n_rise - b_rise, 0);
      check("post_reset_quiet_ferr", n_ferr - b_ferr, 0);
      send_frame(8'h7E, 1'b1, 1'b0, 10, p1);
      drive_level(1'b1, 20);
      check("post_reset_count", n_got - b_got, 1);
      check("post_reset_data", 32'(got[rd]), 32'h7E);
      rd = n_got;

      // Randomized frames: random bytes, gaps and occasional bad stop bits.
      snap();
      n_bad = 0;
      for (int f = 0; f < 10; f++) begin
         rb  = 8'($urandom_range(0, 255));
         bad = ($urandom_range(0, 3) == 0);
         gap = bad ? int'($urandom_range(4, 40)) : int'($urandom_range(0, 40));
         send_frame(rb, !bad, 1'b0, 10, p1);
         if (bad) n_bad++;
         else     exp_q.push_back(rb);
         drive_level(1'b1, gap);
      end
      drive_level(1'b1, 40);
      check("rand_count", n_got - b_got, exp_q.size());
      check("rand_ferr", n_ferr - b_ferr, n_bad);
      check("rand_ovr", n_ovr - b_ovr, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         check($sformatf("rand_byte%0d", i), 32'(got[rd + i]), 32'(exp_q[i]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: the receive end of the 8N1 UART link whose transmit side is `uart_tx`. It oversamples the `rx` pin and majority-votes each bit. Each received byte is presented on a single-entry valid/ready output register, and the block flags framing errors and overruns. It sits beside `uart_tx` in `top`, on the same clock domain, and gives the console a host-to-board debug and command channel.

## Interface
Parameters:
- `CLK_HZ`, default 25_000_000: frequency of `clk` in Hz.
- `BAUD`, default 115_200: line bit rate.
- `OVERSAMPLE`, default 16: sample ticks per bit. Fixed at 16; any other value is an elaboration error.

Ports:
- `clk`  in  1  system clock. One clock; everything is synchronous to its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input. Idle level is high.
- `rx_data`  out  8  received byte, LSB received first. Valid while `rx_valid`=1.
- `rx_valid`  out  1  byte available.
- `rx_ready`  in  1  consumer accepts the byte. A transfer occurs on any cycle with `rx_valid`&&`rx_ready`.
- `frame_err`  out  1  one-cycle pulse: the stop bit was sampled low.
- `overrun`  out  1  one-cycle pulse: a byte completed while `rx_valid`=1, so it was dropped.

## Operation
- Input conditioning: 2-flop synchronizer on `rx` produces `rx_s`. Both flops reset to 1.
- Tick divider: `DIV = (CLK_HZ + BAUD*8) / (BAUD*16)`, integer rounding to nearest. `DIV < 2` is an elaboration error.
  - The divider counter is cleared when a start edge is detected.
  - A sample tick fires every `DIV` clocks after that.
- Sample counter `sc` (4 bits) counts ticks 0..15 within each bit and wraps to 0 at the bit boundary.
- Bit decision: `rx_s` is captured at ticks 7, 8 and 9. The bit value is the majority of the three, decided at tick 9.
- State machine:
  - IDLE: on `rx_s`=0, clear the divider and `sc`, then go to START.
  - START: at tick 9, majority=1 means a false start and the FSM returns to IDLE. Majority=0 continues, and after tick 15 the FSM goes to DATA with bit index 0.
  - DATA: at tick 9, the decided bit is shifted into the MSB of the shift register (a right shift, so LSB-first ends correctly). After tick 15 the bit index increments. After index 7 completes, go to STOP.
  - STOP: at tick 9, majority=1 means deliver the byte, then go directly to IDLE without waiting for tick 15, so the next start edge can be caught early. Majority=0 pulses `frame_err`, discards the byte and goes to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. A held-low line produces exactly one `frame_err`.
- Delivery:
  - If `rx_valid`=0, or if `rx_valid`&&`rx_ready` in the same cycle, load `rx_data` and set `rx_valid`=1.
  - Otherwise pulse `overrun`. `rx_data` and `rx_valid` are unchanged and the new byte is lost.
- `rx_valid` clears on `rx_valid`&&`rx_ready` unless a new byte loads in the same cycle.
- `rx_data` is stable while `rx_valid`=1 and is not pulled by `rx_ready`.

## Timing
- Reset values: `rx_valid`=0, `rx_data`=8'h00, `frame_err`=0, `overrun`=0, FSM in IDLE, divider=0, `sc`=0, shift register=0.
- Reset during a frame aborts it. There is no output activity, and the first start edge seen after reset begins a new frame. A line that is low during reset release is treated as a start edge.
- Latency: the START state is entered on the clock after `rx_s` is first seen low. `rx_valid` rises `(16*9+10)*DIV + 1` clocks after START entry, i.e. stop bit, tick 9, plus one register stage.
- `frame_err` and `overrun` are single-cycle pulses, aligned with the cycle in which `rx_valid` would have loaded.
- Pin-to-`rx_s` delay is 2 clocks.
- Tolerated baud mismatch: at least ±3% total.

## Test plan
Bench parameters: `CLK_HZ`=3_200_000, `BAUD`=100_000, which gives `DIV`=2 and 32 clocks per bit. `rx_ready` is held at 1 unless stated otherwise.
- Byte 8'hA5 sent 8N1 → `rx_data`=8'hA5, `rx_valid` high for exactly one cycle, rising 309 clocks after START entry; no error pulses.
- Back-to-back 8'h00, 8'hFF, 8'h55 with zero idle gap → all three bytes delivered in order, none dropped.
- `rx` glitch low for 8 clocks (4 ticks) in IDLE → false start. No `rx_valid`, and the FSM is back in IDLE before tick 15 of the start bit.
- 8'h3C with the stop bit forced low, then line held low for 200 clocks → exactly one `frame_err` pulse and no `rx_valid`. A following 8'h81 sent after line release is received correctly.
- `rx_ready`=0 while 8'h11 then 8'h22 arrive → `rx_data` stays 8'h11, one `overrun` pulse at the second stop bit. Raising `rx_ready` drops `rx_valid` the next cycle.
- Bits of 8'hC3 each containing a single-clock inverted glitch at tick 8 → `rx_data`=8'hC3 (majority vote holds).
- `reset` asserted mid-DATA → all outputs return to their reset values. The next frame 8'h7E is received correctly.
